bcd_down_counter: RTL

Multi-digit BCD down counter with parallel load. It is the decrementing counterpart of the team's BCD up counter, used for countdown timers and for draining BCD-valued counts in the datapath. Each enabled clock decrements the packed BCD value by one, with digit-wise borrow propagation. Zero detection, a terminal-borrow pulse and load-value validation are provided for the control FSM.

---
 rtl/bcd_down_counter.sv | 85 ++++++++
 1 files changed

// File: rtl/bcd_down_counter.sv
// Multi-digit packed BCD down counter with parallel load, zero detect,
// terminal-borrow pulse and rejected-load pulse.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high clear
//   load       - parallel-load request (wins over enable)
//   load_value - packed BCD value to load, digit 0 in [3:0]
//   enable     - decrement request
//   out        - registered packed BCD count
//   zero       - high while out is all-zero
//   borrow     - one-cycle pulse on decrement from all-zero
//   load_error - one-cycle pulse when a load holds a digit > 9
module bcd_down_counter #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                enable,
  output logic [4*DIGITS-1:0] out,
  output logic                zero,
  output logic                borrow,
  output logic                load_error
);

  logic [4*DIGITS-1:0] dec;
  logic [DIGITS:0]     chain;
  logic                valid;
  logic                term;

  // Per-digit borrow chain: a zero digit that is borrowed from
  // becomes 9 and passes the borrow upward. A borrow out of the
  // top digit means the count was all-zero, and dec is then all
  // nines, which is exactly the wrap value.
  always_comb begin
    dec      = out;
    valid    = 1'b1;
    chain    = '0;
    chain[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9)
        valid = 1'b0;
      if (chain[i]) begin
        if (out[4*i +: 4] == 4'd0) begin
          dec[4*i +: 4] = 4'd9;
          chain[i+1]    = 1'b1;
        end else begin
          dec[4*i +: 4] = out[4*i +: 4] - 4'd1;
          chain[i+1]    = 1'b0;
        end
      end else begin
        chain[i+1] = 1'b0;
      end
    end
  end

  assign term = chain[DIGITS];
  assign zero = (out == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= '0;
      borrow     <= 1'b0;
      load_error <= 1'b0;
    end else begin
      borrow     <= 1'b0;
      load_error <= 1'b0;
      if (load) begin
        if (valid)
          out <= load_value;
        else
          load_error <= 1'b1;
      end else if (enable) begin
        borrow <= term;
        // Without wrap, a decrement from zero holds at zero.
        if (!term || WRAP)
          out <= dec;
      end
    end
  end

endmodule
